// File: rtl/alu_iter.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative unsigned
// multiply (shift-add) and divide/remainder (restoring) behind start/ready/valid.
module alu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       ctrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] hi_o,
    output logic             zero_o,
    output logic             dz_o
);
    // state   | meaning
    // ST_IDLE | ready for a request; single-cycle ops complete from here
    // ST_ITER | multiply/divide in flight, one step per cycle for WIDTH cycles

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_MULU = 4'd3;
    localparam logic [3:0] OP_DIVU = 4'd4;
    localparam logic [3:0] OP_REMU = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_SRA  = 4'd8;
    localparam logic [3:0] OP_LUI  = 4'd9;
    localparam logic [3:0] OP_SRL  = 4'd10;
    localparam logic [3:0] OP_SLL  = 4'd11;
    localparam logic [3:0] OP_NOR  = 4'd12;

    typedef enum logic {ST_IDLE, ST_ITER} state_t;

    state_t           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             dz_q, dz_d;

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sc_result;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    assign shamt = src1_i[SHW-1:0];

    always_comb begin
        sc_result = '0;
        case (ctrl_i)
            OP_AND:  sc_result = src1_i & src2_i;
            OP_OR:   sc_result = src1_i | src2_i;
            OP_ADD:  sc_result = src1_i + src2_i;
            OP_SUB:  sc_result = src1_i - src2_i;
            OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
            OP_SRA:  sc_result = $signed(src2_i) >>> shamt;
            OP_LUI:  sc_result = src2_i << (WIDTH / 2);
            OP_SRL:  sc_result = src2_i >> shamt;
            OP_SLL:  sc_result = src2_i << shamt;
            OP_NOR:  sc_result = ~(src1_i | src2_i);
            default: sc_result = '0;
        endcase
    end

    // Multiply keeps {acc_hi, acc_lo} as partial product / remaining multiplier;
    // divide keeps acc_hi as partial remainder and acc_lo as dividend/quotient.
    assign mul_sum   = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? opnd_q : {WIDTH{1'b0}})};
    assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_ok    = ~div_diff[WIDTH];

    always_comb begin
        if (op_q == OP_MULU) begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end else begin
            step_hi = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            step_lo = {acc_lo_q[WIDTH-2:0], div_ok};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        valid_d  = 1'b0;
        result_d = result_q;
        hi_d     = hi_q;
        dz_d     = dz_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if ((ctrl_i == OP_MULU) ||
                        (((ctrl_i == OP_DIVU) || (ctrl_i == OP_REMU)) && (src2_i != '0))) begin
                        state_d  = ST_ITER;
                        cnt_d    = '0;
                        op_d     = ctrl_i;
                        acc_hi_d = '0;
                        acc_lo_d = src1_i;
                        opnd_d   = src2_i;
                    end else if ((ctrl_i == OP_DIVU) || (ctrl_i == OP_REMU)) begin
                        // divide by zero: quotient all ones, remainder is the dividend
                        valid_d  = 1'b1;
                        dz_d     = 1'b1;
                        result_d = (ctrl_i == OP_DIVU) ? {WIDTH{1'b1}} : src1_i;
                        hi_d     = (ctrl_i == OP_DIVU) ? src1_i : {WIDTH{1'b1}};
                    end else begin
                        valid_d  = 1'b1;
                        dz_d     = 1'b0;
                        result_d = sc_result;
                        hi_d     = '0;
                    end
                end
            end
            ST_ITER: begin
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                cnt_d    = cnt_q + SHW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b1;
                    dz_d    = 1'b0;
                    if (op_q == OP_REMU) begin
                        result_d = step_hi;
                        hi_d     = step_lo;
                    end else if (op_q == OP_DIVU) begin
                        result_d = step_lo;
                        hi_d     = step_hi;
                    end else begin
                        result_d = step_lo;
                        hi_d     = step_hi;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            valid_q  <= 1'b0;
            result_q <= '0;
            hi_q     <= '0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opnd_q   <= opnd_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            dz_q     <= dz_d;
        end
    end

    assign ready_o  = (state_q == ST_IDLE);
    assign valid_o  = valid_q;
    assign result_o = result_q;
    assign hi_o     = hi_q;
    assign zero_o   = (result_q == '0);
    assign dz_o     = dz_q;

endmodule
